reg_file_sb: RTL
================

REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 Parameter DATA_W, default 24, sets the register data width in bits.
REQ-002 Parameter ADDR_W, default 3, sets the register index width; DEPTH = 2**ADDR_W.
REQ-003 Parameter R0_ZERO, default 1: register 0 reads as zero and ignores writes.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 we  in  1  write enable.
REQ-007 waddr  in  ADDR_W  write index.
REQ-008 wdata  in  DATA_W  write data.
REQ-009 rsel1, rsel2  in  ADDR_W  read indices, ports 1 and 2.
REQ-010 rdata1, rdata2  out  DATA_W  combinational read data.
REQ-011 pend_set  in  1  mark register pend_addr as pending, e.g. a load in flight.
REQ-012 pend_addr  in  ADDR_W  index for pend_set.
REQ-013 pend1, pend2  out  1  pending bit of rsel1 and rsel2.
REQ-014 clr_req  in  1  one-cycle pulse that starts a soft-clear sweep.
REQ-015 clr_busy  out  1  high while the sweep runs.

Function
REQ-016 Writes: on a rising clk edge with we=1 and state IDLE, regs[waddr] <= wdata; with R0_ZERO=1 and waddr=0 the write is dropped.
REQ-017 Reads: rdata1 and rdata2 are combinational from the array; with R0_ZERO=1, an index of 0 returns 0.
REQ-018 Scoreboard: pend_set=1 sets bit[pend_addr]; an accepted write clears bit[waddr] on the same edge.
REQ-019 If a set and a clear target the same index on the same edge, the set wins and the bit ends at 1.
REQ-020 With R0_ZERO=1, bit 0 is never set.
REQ-021 pend1 and pend2 are combinational from the scoreboard bits.
REQ-022 FSM states are IDLE and CLEAR.
REQ-023 IDLE -> CLEAR on clr_req=1; on that edge the index counter is loaded with 0 and all scoreboard bits are cleared.
REQ-024 In CLEAR: each cycle regs[cnt] <= 0 and cnt increments.
REQ-025 In CLEAR, when cnt = DEPTH-1 that register is zeroed and the FSM returns to IDLE; the sweep lasts exactly DEPTH cycles.
REQ-026 clr_busy = (state == CLEAR).
REQ-027 In CLEAR, we and pend_set are ignored, and clr_req is ignored without restarting the sweep.
REQ-028 In CLEAR, reads return the current array contents, which are partially cleared.
REQ-029 The counter is ADDR_W bits wide, and wrap-around never occurs in IDLE.

Reset
REQ-030 When rst_n goes low, regardless of clk: all registers reset to 0, scoreboard bits to 0, state to IDLE, cnt to 0, and clr_busy to 0.
REQ-031 Reset asserted mid-sweep aborts the sweep; after release the block is in IDLE with all registers at 0.
REQ-032 The first write is accepted on the first rising edge after rst_n goes high.

Configuration
REQ-033 Macro REG_FILE_SB_BYPASS_EN controls write-to-read forwarding.
REQ-034 With REG_FILE_SB_BYPASS_EN defined: if an accepted write has waddr equal to rsel1 (or rsel2), that port returns wdata in the same cycle, and pend1 (or pend2) reads 0 in that cycle.
REQ-035 Without REG_FILE_SB_BYPASS_EN: reads return the pre-write value until the next edge.
REQ-036 Forwarding never applies to index 0 when R0_ZERO=1, and never applies in CLEAR.

Structure
REQ-037 Package reg_file_sb_pkg holds the FSM state typedef (IDLE, CLEAR) and the default constants DATA_W_DEF=24 and ADDR_W_DEF=3.
REQ-038 The scoreboard is the sub-module reg_file_sb_scoreboard, with ports clk, rst_n, set, set_addr, clr, clr_addr, flush, rsel1, rsel2, pend1 and pend2.
REQ-039 The register array and FSM are in reg_file_sb itself.

Verification
REQ-040 Reset, then we=1, waddr=1, wdata=24'h000009 -> next cycle with rsel1=1, rdata1=24'h000009.
REQ-041 Write waddr=0, wdata=24'hFFFFFF with R0_ZERO=1 -> rdata1 with rsel1=0 stays 0.
REQ-042 pend_set with pend_addr=3, then two cycles later a write to 3 -> pend1 (rsel1=3) reads 1, 1, then 0.
REQ-043 pend_set with pend_addr=3 and a write to 3 on the same edge -> pend1 reads 1 afterwards.
REQ-044 Fill registers 1..7 with nonzero values, pulse clr_req -> clr_busy is high for exactly 8 cycles, writes during it are ignored, and all registers read 0 after it.
REQ-045 With BYPASS_EN, we=1, waddr=2, wdata=24'h00ABCD, rsel2=2 -> rdata2=24'h00ABCD in the same cycle; without BYPASS_EN, rdata2 shows the old value in that cycle.

Source files
------------

// File: rtl/reg_file_sb_pkg.sv
// Shared types and default sizing for the reg_file_sb register file.
// Optional write-to-read forwarding is enabled in the top by REG_FILE_SB_BYPASS_EN.
package reg_file_sb_pkg;

    localparam int DATA_W_DEF = 24;
    localparam int ADDR_W_DEF = 3;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    // Index 0 is hardwired when the zero-register option is on.
    function automatic logic is_zero_reg(input logic r0_zero, input logic idx_is_zero);
        return r0_zero & idx_is_zero;
    endfunction

endpackage

// File: rtl/reg_file_sb_scoreboard.sv
// Pending-bit scoreboard: one bit per register, set by pend_set, cleared by an
// accepted write, flushed wholesale when a clear sweep starts.
import reg_file_sb_pkg::*;

module reg_file_sb_scoreboard #(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter bit R0_ZERO = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              set,
    input  logic [ADDR_W-1:0] set_addr,
    input  logic              clr,
    input  logic [ADDR_W-1:0] clr_addr,
    input  logic              flush,
    input  logic [ADDR_W-1:0] rsel1,
    input  logic [ADDR_W-1:0] rsel2,
    output logic              pend1,
    output logic              pend2
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DEPTH-1:0] pend_r;
    logic [DEPTH-1:0] set_mask_s;
    logic [DEPTH-1:0] clr_mask_s;
    logic [DEPTH-1:0] masked_s;
    logic [DEPTH-1:0] pend_next_s;

    // Next-state bits: clear applied first so a same-index set wins.
    always_comb begin
        set_mask_s  = set ? (DEPTH'(1) << set_addr) : {DEPTH{1'b0}};
        clr_mask_s  = clr ? (DEPTH'(1) << clr_addr) : {DEPTH{1'b0}};
        masked_s    = (pend_r & ~clr_mask_s) | set_mask_s;
        pend_next_s = {masked_s[DEPTH-1:1], (R0_ZERO ? 1'b0 : masked_s[0])};
    end

    // Scoreboard state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_r <= {DEPTH{1'b0}};
        end else if (flush) begin
            pend_r <= {DEPTH{1'b0}};
        end else begin
            pend_r <= pend_next_s;
        end
    end

    assign pend1 = pend_r[rsel1];
    assign pend2 = pend_r[rsel2];

endmodule

// File: rtl/reg_file_sb.sv
// Register file with pending-bit scoreboard and a DEPTH-cycle soft-clear sweep.
// Define REG_FILE_SB_BYPASS_EN to forward an accepted write to matching read ports.
import reg_file_sb_pkg::*;

module reg_file_sb #(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter bit R0_ZERO = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] rsel1,
    input  logic [ADDR_W-1:0] rsel2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    input  logic              pend_set,
    input  logic [ADDR_W-1:0] pend_addr,
    output logic              pend1,
    output logic              pend2,
    input  logic              clr_req,
    output logic              clr_busy
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    state_t            state_r;
    logic [ADDR_W-1:0] cnt_r;
    logic              clr_busy_r;
    logic [DATA_W-1:0] regs_r [DEPTH];

    logic              idle_s;
    logic              wr_acc_s;
    logic              flush_s;
    logic              set_s;
    logic              hit1_s;
    logic              hit2_s;
    logic [DATA_W-1:0] base1_s;
    logic [DATA_W-1:0] base2_s;
    logic              sb_pend1_s;
    logic              sb_pend2_s;

    // Write acceptance and scoreboard controls are only live in IDLE.
    always_comb begin
        idle_s   = (state_r == IDLE);
        wr_acc_s = idle_s & we & ~is_zero_reg(R0_ZERO, (waddr == ADDR_W'(0)));
        flush_s  = idle_s & clr_req;
        set_s    = idle_s & pend_set;
    end

    // Register array, sweep counter and FSM share one sequential process.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            cnt_r      <= {ADDR_W{1'b0}};
            clr_busy_r <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                regs_r[i] <= {DATA_W{1'b0}};
            end
        end else begin
            case (state_r)
                IDLE: begin
                    if (wr_acc_s) begin
                        regs_r[waddr] <= wdata;
                    end
                    if (clr_req) begin
                        state_r    <= CLEAR;
                        cnt_r      <= {ADDR_W{1'b0}};
                        clr_busy_r <= 1'b1;
                    end
                end
                CLEAR: begin
                    regs_r[cnt_r] <= {DATA_W{1'b0}};
                    cnt_r         <= cnt_r + ADDR_W'(1);
                    if (cnt_r == LAST_IDX) begin
                        state_r    <= IDLE;
                        clr_busy_r <= 1'b0;
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    cnt_r      <= {ADDR_W{1'b0}};
                    clr_busy_r <= 1'b0;
                end
            endcase
        end
    end

    reg_file_sb_scoreboard #(
        .ADDR_W  (ADDR_W),
        .R0_ZERO (R0_ZERO)
    ) u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .set      (set_s),
        .set_addr (pend_addr),
        .clr      (wr_acc_s),
        .clr_addr (waddr),
        .flush    (flush_s),
        .rsel1    (rsel1),
        .rsel2    (rsel2),
        .pend1    (sb_pend1_s),
        .pend2    (sb_pend2_s)
    );

    // Read ports; wr_acc_s already excludes index 0 and the CLEAR state.
    always_comb begin
        base1_s = is_zero_reg(R0_ZERO, (rsel1 == ADDR_W'(0))) ? {DATA_W{1'b0}} : regs_r[rsel1];
        base2_s = is_zero_reg(R0_ZERO, (rsel2 == ADDR_W'(0))) ? {DATA_W{1'b0}} : regs_r[rsel2];
`ifdef REG_FILE_SB_BYPASS_EN
        hit1_s  = wr_acc_s & (waddr == rsel1);
        hit2_s  = wr_acc_s & (waddr == rsel2);
`else
        hit1_s  = 1'b0;
        hit2_s  = 1'b0;
`endif
        rdata1  = hit1_s ? wdata : base1_s;
        rdata2  = hit2_s ? wdata : base2_s;
        pend1   = hit1_s ? 1'b0 : sb_pend1_s;
        pend2   = hit2_s ? 1'b0 : sb_pend2_s;
    end

    assign clr_busy = clr_busy_r;

endmodule
